// File: rtl/ucode_mul_seq.sv
// Microcode multiply sequencer: expands MULI/MULR/MULSI/MULSR into MOV/ADD(S)/SUBI/NOT/SUB(S)
// injected through the IF/ID mux. Optional min-iteration operand swap under UCODE_MIN_ITER_EN.
module ucode_mul_seq #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16,
  parameter int CNT_W  = 32,
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_mul,
  input  logic [1:0]        mul_type,
  input  logic [REG_AW-1:0] dest_reg,
  input  logic [REG_AW-1:0] source_reg,
`ifdef UCODE_MIN_ITER_EN
  input  logic [REG_AW-1:0] source_reg2,
`endif
  input  logic [IMM_W-1:0]  immediate,
  input  logic [DATA_W-1:0] read_data_second,
  input  logic [DATA_W-1:0] read_data_first,
  input  logic [3:0]        flags_in,
  input  logic              inject_ready,
  input  logic              abort,
  output logic [31:0]       output_instruction,
  output logic              mux_ctrl,
  output logic              busy,
  output logic              mul_release,
  output logic [3:0]        flags_back_out,
  output logic              flags_restore
);

  localparam logic [31:0] NOP     = {5'b11001, 27'b0};
  localparam logic [6:0]  OP_ADD  = 7'b0110001;
  localparam logic [6:0]  OP_ADDS = 7'b0111001;
  localparam logic [6:0]  OP_SUB  = 7'b0110010;
  localparam logic [6:0]  OP_SUBS = 7'b0111010;
  localparam logic [6:0]  OP_SUBI = 7'b0010010;
  localparam logic [6:0]  OP_NOT  = 7'b0110110;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_MOV, S_ADD, S_NEG1, S_NEG2, S_DONE
  } state_t;

  // Register fields in the instruction word are fixed at 4 bits.
  function automatic logic [3:0] f4(input logic [REG_AW-1:0] r);
    return 4'(r);
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] op, input logic [REG_AW-1:0] rd,
                                        input logic [REG_AW-1:0] rs1, input logic [REG_AW-1:0] rs2);
    return {op, f4(rd), f4(rs1), f4(rs2), 13'b0};
  endfunction

  function automatic logic [31:0] enc_mov(input logic [REG_AW-1:0] rd);
    return {7'b0000000, f4(rd), 5'b0, 16'b0};
  endfunction

  function automatic logic [31:0] enc_subi(input logic [REG_AW-1:0] rd);
    return {OP_SUBI, f4(rd), f4(rd), 1'b0, 16'd1};
  endfunction

  function automatic logic [31:0] enc_not(input logic [REG_AW-1:0] rd);
    return {OP_NOT, f4(rd), f4(rd), 17'b0};
  endfunction

  function automatic logic [CNT_W-1:0] mag(input logic [CNT_W-1:0] v);
    return v[CNT_W-1] ? CNT_W'(-v) : v;
  endfunction

  state_t              state;
  logic [REG_AW-1:0]   rd_q, src_q;
  logic                s_q, neg_q;
  logic [3:0]          flags_q;
  logic [CNT_W-1:0]    cnt;

  logic [CNT_W-1:0]    m_sx, m_abs;
  logic [REG_AW-1:0]   src_sel;
  logic                s_in;

  assign s_in = mul_type[1];

  // Multiplier selection; min-int magnitude fits CNT_W because it is read as unsigned.
  always_comb begin
    m_sx    = mul_type[0] ? CNT_W'($signed(read_data_second)) : CNT_W'($signed(immediate));
    src_sel = source_reg;
`ifdef UCODE_MIN_ITER_EN
    if (mul_type[0] && (mag(CNT_W'($signed(read_data_first))) < mag(m_sx))) begin
      m_sx    = CNT_W'($signed(read_data_first));
      src_sel = source_reg2;
    end
`endif
    m_abs = mag(m_sx);
  end

`ifndef UCODE_MIN_ITER_EN
  logic unused_rdf;
  assign unused_rdf = ^read_data_first;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= S_IDLE;
      rd_q               <= '0;
      src_q              <= '0;
      s_q                <= 1'b0;
      neg_q              <= 1'b0;
      flags_q            <= '0;
      cnt                <= '0;
      output_instruction <= NOP;
      mux_ctrl           <= 1'b0;
      busy               <= 1'b0;
      mul_release        <= 1'b0;
      flags_back_out     <= '0;
      flags_restore      <= 1'b0;
    end else begin
      mul_release <= 1'b0;
      if (abort && state != S_IDLE) begin
        state              <= S_IDLE;
        output_instruction <= NOP;
        mux_ctrl           <= 1'b0;
        busy               <= 1'b0;
        flags_back_out     <= '0;
        flags_restore      <= 1'b0;
      end else begin
        case (state)
          S_IDLE: if (start_mul) begin
            rd_q     <= dest_reg;
            src_q    <= src_sel;
            s_q      <= s_in;
            neg_q    <= m_sx[CNT_W-1];
            flags_q  <= flags_in;
            cnt      <= m_abs;
            mux_ctrl <= 1'b1;
            busy     <= 1'b1;
            if (m_abs == '0) begin
              state              <= S_CLEAR;
              output_instruction <= enc_r(s_in ? OP_SUBS : OP_SUB, dest_reg, dest_reg, dest_reg);
            end else begin
              state              <= S_MOV;
              output_instruction <= enc_mov(dest_reg);
            end
          end
          S_CLEAR: if (inject_ready) begin
            state              <= S_DONE;
            output_instruction <= NOP;
            mux_ctrl           <= 1'b0;
            mul_release        <= 1'b1;
            flags_back_out     <= flags_q;
            flags_restore      <= ~s_q;
          end
          S_MOV: if (inject_ready) begin
            state              <= S_ADD;
            output_instruction <= enc_r(s_q ? OP_ADDS : OP_ADD, rd_q, rd_q, src_q);
          end
          S_ADD: if (inject_ready) begin
            cnt <= cnt - 1'b1;
            if (cnt == CNT_W'(1)) begin
              if (neg_q) begin
                state              <= S_NEG1;
                output_instruction <= enc_subi(rd_q);
              end else begin
                state              <= S_DONE;
                output_instruction <= NOP;
                mux_ctrl           <= 1'b0;
                mul_release        <= 1'b1;
                flags_back_out     <= flags_q;
                flags_restore      <= ~s_q;
              end
            end
          end
          // Two's-complement negate of the positive product: -(x) = ~(x - 1).
          S_NEG1: if (inject_ready) begin
            state              <= S_NEG2;
            output_instruction <= enc_not(rd_q);
          end
          S_NEG2: if (inject_ready) begin
            state              <= S_DONE;
            output_instruction <= NOP;
            mux_ctrl           <= 1'b0;
            mul_release        <= 1'b1;
            flags_back_out     <= flags_q;
            flags_restore      <= ~s_q;
          end
          S_DONE: begin
            state          <= S_IDLE;
            busy           <= 1'b0;
            flags_back_out <= '0;
            flags_restore  <= 1'b0;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/ucode_mul_seq.md
Name: ucode_mul_seq

Overview:
Parametrised microcode sequencer that expands MULI/MULR/MULSI/MULSR into injected MOV/ADD(S)/SUBI/NOT/SUB(S) instructions. It sits between ID and the IF/ID instruction mux and drives the mux select while it owns the pipeline. Over the first-generation sequencer it adds:
- generic widths;
- a pipeline back-pressure handshake and a flush/abort input;
- correct signed fix-up on every variant;
- a busy flag.

Parameters:
DATA_W, 32, register data width (multiplier operand from the register file).
IMM_W, 16, immediate field width.
CNT_W, 32, iteration counter width; must be >= max(DATA_W, IMM_W).
REG_AW, 4, register address width.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start_mul  in  1  one-cycle pulse from ID: MUL decoded.
mul_type  in  2  0=MULI, 1=MULR, 2=MULSI, 3=MULSR.
dest_reg  in  REG_AW  Rd.
source_reg  in  REG_AW  register added each iteration.
immediate  in  IMM_W  signed multiplier (MULI/MULSI).
read_data_second  in  DATA_W  signed multiplier value (MULR/MULSR).
read_data_first  in  DATA_W  value of source_reg; used only with the optional feature.
flags_in  in  4  NZCV from execute.
inject_ready  in  1  pipeline accepts the injected instruction this cycle.
abort  in  1  synchronous flush (branch redirect).
output_instruction  out  32  injected instruction; NOP {5'b11001,27'b0} when idle.
mux_ctrl  out  1  1 = pipeline takes output_instruction.
busy  out  1  high from the cycle after acceptance until return to IDLE.
mul_release  out  1  one-cycle pulse on completion.
flags_back_out  out  4  flags to restore, valid with mul_release.
flags_restore  out  1  1 = execute must overwrite flags with flags_back_out (MULI/MULR only).

Behaviour:
Reset (rst_n=0, async):
- state IDLE; all counters and captured registers 0.
- output_instruction=NOP, mux_ctrl=0, busy=0, mul_release=0, flags_back_out=0, flags_restore=0.

Acceptance (start_mul=1 in IDLE):
- Capture Rd, source_reg, mul_type and flags_in.
- Multiplier m = sign-extended immediate (MULI/MULSI) or read_data_second (MULR/MULSR).
- Count = |m| zero-extended to CNT_W; 0x8000 gives 32768 and DATA_W min-int gives 2^(DATA_W-1); no overflow is possible.
- neg = sign bit of m.
- start_mul outside IDLE is ignored.

Opcode fields:
- R-type: {op7, rd, rs1, rs2, 13'b0}.
- MOV: {7'b0000000, rd, 5'b0, 16'b0}.
- SUBI: {7'b0010010, rd, rd, 1'b0, 16'd1}.
- NOT: {7'b0110110, rd, rd, 17'b0}.
- ADD 0110001, ADDS 0111001, SUB 0110010, SUBS 0111010.

States (each emitting state drives mux_ctrl=1 and holds its instruction and state while inject_ready=0):
- IDLE: mux_ctrl=0, NOP. Accept -> CLEAR if count==0, else MOV.
- CLEAR: SUB rd,rd,rd (SUBS for S-variants) -> DONE.
- MOV: MOV rd,#0 -> ADD.
- ADD: ADD rd,rd,src (ADDS for S-variants); count decrements per accepted issue. After the accept that brings count to 0 -> NEG1 if neg, else DONE.
- NEG1: SUBI rd,rd,#1 -> NEG2.
- NEG2: NOT rd,rd -> DONE.
- DONE: NOP, mux_ctrl=0, mul_release=1 for one cycle, flags_back_out=captured flags, flags_restore=1 for MULI/MULR and 0 for S-variants (flags come from the last executed op) -> IDLE.

Emitted instruction count for |m|=N:
- 1 when N=0.
- N+1 when N>0 and m>=0.
- N+3 when m<0.

Abort:
- Any non-IDLE state -> IDLE next cycle; mul_release stays 0; busy drops.
- Abort has priority over inject_ready and over start_mul in the same cycle.

Optional Feature:
UCODE_MIN_ITER_EN:
- When defined, MULR/MULSR compare |read_data_first| with |read_data_second| at acceptance. If |read_data_first| is smaller, the sequencer adds register rs2 (from a new input source_reg2, REG_AW wide) |read_data_first| times, with neg = sign of read_data_first. Ties keep the normal order. Iterations become min(|a|,|b|).
- When undefined, read_data_first and source_reg2 are unused and behaviour is exactly as above.

Test Plan:
- MULI Rd=1, src=0, imm=3, inject_ready=1 -> MOV, ADD x3, release on cycle 5 after start, flags_restore=1 with captured flags.
- MULSI imm=0xFFFE (-2) -> MOV, ADDS, ADDS, SUBI #1, NOT, release; Rd ends at -2*src in the model.
- MULR read_data_second=0 -> single SUB rd,rd,rd, then release; MULSR with the same value -> SUBS.
- MULI imm=2 with inject_ready low for 3 cycles during the first ADD -> the ADD is held stable and the total sequence is still MOV, ADD, ADD.
- Abort asserted during the second ADD of imm=5 -> IDLE next cycle, no mul_release, a new start 1 cycle later is accepted.
- rst_n low mid-sequence -> all outputs immediately at reset values; with UCODE_MIN_ITER_EN, MULR a=2, b=100 -> 2 ADDs of rs2.
